// File: rtl/serv_ibus_resp.sv
// rtl/serv_ibus_resp.sv - Wishbone instruction-fetch responder over a synchronous word memory
// One fetch at a time: IDLE -> READ -> WAIT(xWAIT) -> ACK, with out-of-range fetches returning zero.
module serv_ibus_resp #(
  parameter int AW   = 10,
  parameter int WAIT = 0
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic [29:0]   i_wb_adr,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic          o_mem_en,
  output logic [AW-1:0] o_mem_addr,
  input  logic [31:0]   i_mem_rdata,
  output logic          o_oor
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_ACK} state_t;

  localparam logic [2:0] CNT_INIT = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [31:0] data_q;
  logic        ack_q;
  logic        oor_q;
  logic        oor_pend_q;

  logic [29:0] hi_bits;
  logic        in_range;
  logic        accept;

  assign hi_bits  = i_wb_adr >> AW;
  assign in_range = (hi_bits == '0);
  assign accept   = !i_rst && (state_q == S_IDLE) && i_wb_cyc;

  // Memory is only touched for in-range addresses, and only in the accepting cycle.
  assign o_mem_en   = accept && in_range;
  assign o_mem_addr = i_wb_adr[AW-1:0];

  assign o_wb_rdt = data_q;
  assign o_wb_ack = ack_q;
  assign o_oor    = oor_q;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      data_q     <= 32'h0;
      ack_q      <= 1'b0;
      oor_q      <= 1'b0;
      oor_pend_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      oor_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_wb_cyc) begin
            oor_pend_q <= !in_range;
            state_q    <= S_READ;
          end
        end
        S_READ: begin
          data_q <= oor_pend_q ? 32'h0 : i_mem_rdata;
          if (!i_wb_cyc) begin
            state_q <= S_IDLE;
          end else if (WAIT > 0) begin
            state_q <= S_WAIT;
            cnt_q   <= CNT_INIT;
          end else begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            oor_q   <= oor_pend_q;
          end
        end
        S_WAIT: begin
          if (!i_wb_cyc) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
          end else if (cnt_q == 3'd0) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
            oor_q   <= oor_pend_q;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serv_ibus_resp.sv
// tb/tb_serv_ibus_resp.sv - directed bench for serv_ibus_resp with WAIT=0 and WAIT=3 instances
// Instance 0 uses WAIT=0, instance 1 uses WAIT=3; each has its own memory read port model.
module tb_serv_ibus_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc      [2];
  logic [29:0] adr      [2];
  logic [31:0] rdt      [2];
  logic        ack      [2];
  logic        mem_en   [2];
  logic [9:0]  mem_addr [2];
  logic [31:0] mem_rdata[2];
  logic        oor      [2];

  logic [31:0] mem [1024];
  int          wt [2] = '{0, 3};
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  serv_ibus_resp #(.AW(10), .WAIT(0)) dut0 (
    .clk(clk), .i_rst(rst), .i_wb_adr(adr[0]), .i_wb_cyc(cyc[0]),
    .o_wb_rdt(rdt[0]), .o_wb_ack(ack[0]), .o_mem_en(mem_en[0]),
    .o_mem_addr(mem_addr[0]), .i_mem_rdata(mem_rdata[0]), .o_oor(oor[0])
  );

  serv_ibus_resp #(.AW(10), .WAIT(3)) dut1 (
    .clk(clk), .i_rst(rst), .i_wb_adr(adr[1]), .i_wb_cyc(cyc[1]),
    .o_wb_rdt(rdt[1]), .o_wb_ack(ack[1]), .o_mem_en(mem_en[1]),
    .o_mem_addr(mem_addr[1]), .i_mem_rdata(mem_rdata[1]), .o_oor(oor[1])
  );

  always @(posedge clk) begin
    if (mem_en[0]) mem_rdata[0] <= mem[mem_addr[0]];
    if (mem_en[1]) mem_rdata[1] <= mem[mem_addr[1]];
  end

  // Starts cycle N at the current post-edge instant; returns just after the edge ending the ack cycle.
  task automatic fetch(input int d, input logic [29:0] a, input logic [31:0] exp_rdt,
                       input logic exp_oor, input string tag);
    int lat;
    int ens;
    lat = -1;
    ens = 0;
    cyc[d] = 1'b1;
    adr[d] = a;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin
        total++;
        if (mem_en[d] !== !exp_oor) begin
          bad++;
          $display("FAIL %s mem_en@N: got %b want %b", tag, mem_en[d], !exp_oor);
        end
        if (!exp_oor) begin
          total++;
          if (mem_addr[d] !== a[9:0]) begin
            bad++;
            $display("FAIL %s mem_addr: got %h want %h", tag, mem_addr[d], a[9:0]);
          end
        end
      end else if (mem_en[d] === 1'b1) begin
        ens++;
      end
      if (ack[d] === 1'b1) begin
        lat = k;
        total++;
        if (rdt[d] !== exp_rdt) begin
          bad++;
          $display("FAIL %s rdt: got %h want %h", tag, rdt[d], exp_rdt);
        end
        total++;
        if (oor[d] !== exp_oor) begin
          bad++;
          $display("FAIL %s oor: got %b want %b", tag, oor[d], exp_oor);
        end
      end
      @(posedge clk);
      #1;
      if (k == 0) adr[d] = ~a;
    end
    total++;
    if (lat != 2 + wt[d]) begin
      bad++;
      $display("FAIL %s ack latency: got %0d want %0d (-1 = no ack)", tag, lat, 2 + wt[d]);
    end
    total++;
    if (ens != 0) begin
      bad++;
      $display("FAIL %s extra mem_en pulses: got %0d want 0", tag, ens);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 1'b1;
      adr[d] = 30'h5;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        total++;
        if (ack[d] !== 1'b0 || oor[d] !== 1'b0 || mem_en[d] !== 1'b0 || rdt[d] !== 32'h0) begin
          bad++;
          $display("FAIL reset dut%0d: ack=%b oor=%b en=%b rdt=%h want 0 0 0 0",
                   d, ack[d], oor[d], mem_en[d], rdt[d]);
        end
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc[0] = 1'b0;
    cyc[1] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    fetch(0, 30'h5, 32'h00500093, 1'b0, "basic_w0");
    cyc[0] = 1'b0;
    fetch(1, 30'h5, 32'h00500093, 1'b0, "basic_w3");
    cyc[1] = 1'b0;
  endtask

  task automatic test_oor();
    fetch(0, 30'h400, 32'h0, 1'b1, "oor_w0");
    cyc[0] = 1'b0;
    fetch(1, 30'h3FFF_FFFF, 32'h0, 1'b1, "oor_w3");
    cyc[1] = 1'b0;
  endtask

  task automatic test_abort();
    cyc[1] = 1'b1;
    adr[1] = 30'h3;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    cyc[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (ack[1] !== 1'b0 || oor[1] !== 1'b0) begin
        bad++;
        $display("FAIL abort cycle %0d: ack=%b oor=%b want 0 0", k + 2, ack[1], oor[1]);
      end
      @(posedge clk);
      #1;
    end
    fetch(1, 30'h7, mem[7], 1'b0, "abort_refetch");
    cyc[1] = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 2; d++) begin
      fetch(d, 30'h0, mem[0], 1'b0, "b2b_0");
      fetch(d, 30'h1, mem[1], 1'b0, "b2b_1");
      fetch(d, 30'h2, mem[2], 1'b0, "b2b_2");
      cyc[d] = 1'b0;
    end
  endtask

  task automatic test_rst_mid();
    cyc[0] = 1'b1;
    adr[0] = 30'h9;
    @(negedge clk);
    total++;
    if (mem_en[0] !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid en@N: got %b want 1", mem_en[0]);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (mem_en[0] !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid en during reset: got %b want 0", mem_en[0]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (ack[0] !== 1'b0 || rdt[0] !== 32'h0) begin
        bad++;
        $display("FAIL rst_mid post cycle %0d: ack=%b rdt=%h want 0 00000000", k, ack[0], rdt[0]);
      end
      @(posedge clk);
      #1;
    end
    fetch(0, 30'h5, 32'h00500093, 1'b0, "rst_mid_refetch");
    cyc[0] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 ^ (i * 32'h0101_0011);
    mem[5] = 32'h00500093;
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 1'b0;
      adr[d] = 30'h0;
      mem_rdata[d] = 32'hDEAD_BEEF;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_oor();
    test_abort();
    test_back_to_back();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serv_ibus_resp.md
SERV_IBUS_RESP -- requirements
Module: serv_ibus_resp

Interface
REQ-001 Parameter AW, default 10: word-address width of the backing instruction memory (2^AW 32-bit words).
REQ-002 Parameter WAIT, default 0: extra wait states inserted before acknowledge, legal range 0..7.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port i_rst  input  1  reset, synchronous and active-high.
REQ-005 Port i_wb_adr  input  30  instruction word address, byte address bits 31:2.
REQ-006 Port i_wb_cyc  input  1  fetch request from the core, held until acknowledge.
REQ-007 Port o_wb_rdt  output  32  instruction word returned to the core.
REQ-008 Port o_wb_ack  output  1  single-cycle acknowledge; o_wb_rdt is valid in this cycle.
REQ-009 Port o_mem_en  output  1  synchronous memory read enable.
REQ-010 Port o_mem_addr  output  AW  memory word address.
REQ-011 Port i_mem_rdata  input  32  memory read data, valid one cycle after o_mem_en.
REQ-012 Port o_oor  output  1  single-cycle pulse concurrent with an out-of-range acknowledge.

Function
REQ-013 FSM states: IDLE, READ, WAIT, ACK.
REQ-014 Cycle N is the first cycle with state IDLE and i_wb_cyc=1; the request is accepted in cycle N.
REQ-015 In-range request (i_wb_adr[29:AW] all zero): o_mem_en=1 combinationally in cycle N only, o_mem_addr=i_wb_adr[AW-1:0]; next state READ.
REQ-016 o_mem_en SHALL be 0 in every state other than accepting IDLE, and 0 while i_rst=1.
REQ-017 READ (cycle N+1): capture i_mem_rdata into the data register; next state WAIT if WAIT>0, else ACK.
REQ-018 WAIT: 3-bit counter loaded with WAIT-1 on entry and decremented each cycle; leave for ACK when the counter reads 0, giving exactly WAIT cycles in WAIT.
REQ-019 ACK: o_wb_ack=1 for exactly one cycle, N+2+WAIT, registered output; next state IDLE unconditionally.
REQ-020 Out-of-range request: no memory access; data register loaded with 32'h0 at the READ edge. Latency, WAIT handling and ack timing are identical to an in-range request.
REQ-021 o_oor=1 only in the ACK cycle of an out-of-range request.
REQ-022 o_wb_rdt is driven from the data register and holds its last value between acknowledges.
REQ-023 i_wb_adr is sampled only in cycle N; changes in later cycles of the same transaction are ignored.
REQ-024 Abort: i_wb_cyc=0 while in READ or WAIT; next state IDLE, no ack, no o_oor. The data register may update at that edge.
REQ-025 Requests are not pipelined: at most one outstanding transaction; the cycle after ACK is always IDLE.
REQ-026 A request presented in the cycle immediately after ACK with i_wb_cyc=1 is accepted as a new transaction.

Reset
REQ-027 While i_rst=1: state is IDLE, o_wb_ack=0, o_oor=0, o_mem_en=0, the WAIT counter is 0, and the data register is 32'h0.
REQ-028 Reset asserted mid-transaction discards the transaction; no ack follows after reset is released.
REQ-029 i_wb_cyc is ignored in any cycle where i_rst=1.

Verification
REQ-030 WAIT=0, AW=10: cyc=1, adr=30'h5, mem[5]=32'h00500093. Required: o_mem_en pulse in cycle N with o_mem_addr=5, then o_wb_ack in cycle N+2 with rdt=32'h00500093, o_oor=0.
REQ-031 WAIT=3: same fetch as REQ-030. Required: ack in cycle N+5 only; exactly one o_mem_en pulse.
REQ-032 AW=10: adr=30'h400. Required: no o_mem_en, ack in cycle N+2+WAIT with rdt=32'h0 and o_oor=1.
REQ-033 WAIT=3: cyc dropped in cycle N+2. Required: no ack; a new request at adr=7 is accepted in cycle N+4 or later and acks normally with mem[7].
REQ-034 Back-to-back fetches of adr 0,1,2 with cyc re-asserted the cycle after each ack. Required: three acks spaced 3+WAIT cycles apart, each returning the matching word.
REQ-035 i_rst pulsed in cycle N+1 of a fetch. Required: no ack, o_wb_rdt=32'h0, state IDLE; the next request behaves as in REQ-030.
